fp_add_seq: RTL and testbench

FP_ADD_SEQ -- requirements
Module: fp_add_seq

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_unpack.sv | 54 +++++
 rtl/fp_add_seq.sv | 167 ++++++++++++++++
 tb/tb_fp_add_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential single-precision adder:
// FSM state encoding, field widths and canonical constants.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } fsm_state_t;

  localparam int          MANT_W      = 23;
  localparam logic [7:0]  EXP_MAX     = 8'd255;
  localparam logic [7:0]  ALIGN_LIMIT = 8'd26;
  localparam logic [31:0] QNAN        = 32'h7FC0_0000;
  localparam logic [31:0] POS_ZERO    = 32'h0000_0000;

  // Sign plus 24-bit mantissa with the hidden bit already inserted.
  typedef struct packed {
    logic              sign;
    logic [MANT_W:0]   mant;
  } fp_mant_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational operand unpacker: splits fields, inserts the hidden bit,
// flags zero/special operands and orders the pair by magnitude.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output fp_mant_t    x_o,
  output fp_mant_t    y_o,
  output logic [7:0]  x_exp_o,
  output logic [7:0]  d_o,
  output logic        a_zero_o,
  output logic        b_zero_o,
  output logic        a_special_o,
  output logic        b_special_o
);

  logic [7:0]  a_exp;
  logic [7:0]  b_exp;
  logic [23:0] a_mant;
  logic [23:0] b_mant;
  logic        a_ge_b;

  always_comb begin
    a_exp  = a_i[30:23];
    b_exp  = b_i[30:23];
    a_mant = {1'b1, a_i[MANT_W-1:0]};
    b_mant = {1'b1, b_i[MANT_W-1:0]};
    // Exponent-then-fraction ordering equals magnitude ordering for normals.
    a_ge_b = (a_i[30:0] >= b_i[30:0]);

    a_zero_o    = (a_exp == 8'd0);
    b_zero_o    = (b_exp == 8'd0);
    a_special_o = (a_exp == EXP_MAX);
    b_special_o = (b_exp == EXP_MAX);

    if (a_ge_b) begin
      x_o.sign = a_i[31];
      x_o.mant = a_mant;
      y_o.sign = b_i[31];
      y_o.mant = b_mant;
      x_exp_o  = a_exp;
      d_o      = a_exp - b_exp;
    end else begin
      x_o.sign = b_i[31];
      x_o.mant = b_mant;
      y_o.sign = a_i[31];
      y_o.mant = a_mant;
      x_exp_o  = b_exp;
      d_o      = b_exp - a_exp;
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder, one FSM action per clock,
// truncating rounding and flush-to-zero of denormal operands.
module fp_add_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy,
  output fsm_state_t  state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE; out_valid only in DONE, where
  // result stays frozen until out_ready is seen, then the FSM returns to IDLE.

  fsm_state_t  state_q,    state_d;
  logic        x_sign_q,   x_sign_d;
  logic        eff_sub_q,  eff_sub_d;
  logic [9:0]  x_exp_q,    x_exp_d;
  logic [23:0] x_mant_q,   x_mant_d;
  logic [23:0] y_mant_q,   y_mant_d;
  logic [7:0]  d_q,        d_d;
  logic [24:0] sum_q,      sum_d;
  logic [31:0] result_q,   result_d;

  fp_mant_t    un_x;
  fp_mant_t    un_y;
  logic [7:0]  un_x_exp;
  logic [7:0]  un_d;
  logic        a_zero, b_zero, a_special, b_special;

  fp_unpack u_unpack (
    .a_i         (A),
    .b_i         (B),
    .x_o         (un_x),
    .y_o         (un_y),
    .x_exp_o     (un_x_exp),
    .d_o         (un_d),
    .a_zero_o    (a_zero),
    .b_zero_o    (b_zero),
    .a_special_o (a_special),
    .b_special_o (b_special)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      x_sign_q  <= 1'b0;
      eff_sub_q <= 1'b0;
      x_exp_q   <= '0;
      x_mant_q  <= '0;
      y_mant_q  <= '0;
      d_q       <= '0;
      sum_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      x_sign_q  <= x_sign_d;
      eff_sub_q <= eff_sub_d;
      x_exp_q   <= x_exp_d;
      x_mant_q  <= x_mant_d;
      y_mant_q  <= y_mant_d;
      d_q       <= d_d;
      sum_q     <= sum_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_sign_d  = x_sign_q;
    eff_sub_d = eff_sub_q;
    x_exp_d   = x_exp_q;
    x_mant_d  = x_mant_q;
    y_mant_d  = y_mant_q;
    d_d       = d_q;
    sum_d     = sum_q;
    result_d  = result_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (a_special) begin
            result_d = A;
            state_d  = DONE;
          end else if (b_special) begin
            result_d = B;
            state_d  = DONE;
          end else if (a_zero && b_zero) begin
            result_d = POS_ZERO;
            state_d  = DONE;
          end else if (a_zero) begin
            result_d = B;
            state_d  = DONE;
          end else if (b_zero) begin
            result_d = A;
            state_d  = DONE;
          end else begin
            x_sign_d  = un_x.sign;
            eff_sub_d = un_x.sign ^ un_y.sign;
            x_exp_d   = {2'b00, un_x_exp};
            x_mant_d  = un_x.mant;
            d_d       = un_d;
            y_mant_d  = un_y.mant;
            if (un_d == 8'd0) begin
              state_d = ADD;
            end else if (un_d >= ALIGN_LIMIT) begin
              // Y is shifted entirely out; skip the long alignment walk.
              y_mant_d = '0;
              state_d  = ADD;
            end else begin
              state_d = ALIGN;
            end
          end
        end
      end
      ALIGN: begin
        y_mant_d = y_mant_q >> 1;
        d_d      = d_q - 8'd1;
        if (d_q == 8'd1) state_d = ADD;
      end
      ADD: begin
        if (eff_sub_q) sum_d = {1'b0, x_mant_q} - {1'b0, y_mant_q};
        else           sum_d = {1'b0, x_mant_q} + {1'b0, y_mant_q};
        state_d = NORM;
      end
      NORM: begin
        if (sum_q == 25'd0) begin
          result_d = POS_ZERO;
          state_d  = DONE;
        end else if (sum_q[24]) begin
          sum_d   = sum_q >> 1;
          x_exp_d = x_exp_q + 10'd1;
        end else if (!sum_q[23]) begin
          sum_d   = sum_q << 1;
          x_exp_d = x_exp_q - 10'd1;
          if (x_exp_q == 10'd1) begin
            result_d = {x_sign_q, 31'd0};
            state_d  = DONE;
          end
        end else begin
          if (x_exp_q >= {2'b00, EXP_MAX}) result_d = {x_sign_q, EXP_MAX, 23'd0};
          else                             result_d = {x_sign_q, x_exp_q[7:0], sum_q[22:0]};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: directed corner cases plus randomized
// operands checked against a plain-arithmetic reference model.
module tb_fp_add_seq;
  import fp_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
  fsm_state_t  state_o;

  int checks = 0;
  int errors = 0;

  fsm_state_t  trace_q[$];
  logic [31:0] exp_q[$];

  fp_add_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .state_o   (state_o)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, ex, ey, p, e;
    longint      mx, my, s;
    logic        sx;
    logic [31:0] x, y;
    logic [22:0] frac;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 && eb == 0) return 32'h0;
    if (ea == 0) return b;
    if (eb == 0) return a;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sx = x[31];
    mx = longint'({1'b1, x[22:0]});
    my = longint'({1'b1, y[22:0]});
    my = my >> (ex - ey);
    s  = (x[31] == y[31]) ? (mx + my) : (mx - my);
    if (s == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 25; i++) if (s[i]) p = i;
    e = ex + p - 23;
    if (p < 23 && e <= 0) return {sx, 31'd0};
    if (e >= 255) return {sx, 8'hFF, 23'd0};
    if (p > 23) s = s >> (p - 23);
    else        s = s << (23 - p);
    frac = s[22:0];
    return {sx, e[7:0], frac};
  endfunction

  // ---------------- driver tasks ----------------
  // Offers one operand pair, records the state seen at each falling edge,
  // and returns once out_valid is up (result is left unconsumed).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res);
    int n;
    trace_q.delete();
    @(negedge clk);
    A = a;
    B = b;
    in_valid = 1'b1;
    trace_q.push_back(state_o);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      trace_q.push_back(state_o);
      if (out_valid) break;
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL timeout a=%08h b=%08h out_valid=%0b required 1", a, b, out_valid);
    end
    res = result;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (state_o !== IDLE) begin errors++; $display("FAIL reset_state got %0d required %0d", state_o, IDLE); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b required 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %08h required 00000000", result); end
    reset = 1'b0;
  endtask

  task automatic test_one_plus_one();
    logic [31:0] res;
    fsm_state_t  exp_tr[5];
    exp_tr = '{IDLE, ADD, NORM, NORM, DONE};
    run_op(32'h3F80_0000, 32'h3F80_0000, res);
    checks++;
    if (trace_q.size() != 5) begin
      errors++;
      $display("FAIL one_plus_one_len got %0d required 5", trace_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (trace_q[i] !== exp_tr[i]) begin
          errors++;
          $display("FAIL one_plus_one_state[%0d] got %0d required %0d", i, trace_q[i], exp_tr[i]);
        end
      end
    end
    checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL one_plus_one_result got %08h required 40000000", res); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_busy got %0b required 1", busy); end
    consume();
  endtask

  task automatic test_align_one();
    logic [31:0] res;
    int n_align;
    run_op(32'h4040_0000, 32'hBF80_0000, res);
    n_align = 0;
    foreach (trace_q[i]) if (trace_q[i] == ALIGN) n_align++;
    checks++; if (n_align != 1) begin errors++; $display("FAIL align_cycles got %0d required 1", n_align); end
    checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL three_minus_one got %08h required 40000000", res); end
    consume();
  endtask

  task automatic test_cancel_and_overflow();
    logic [31:0] res;
    run_op(32'h3F80_0000, 32'hBF80_0000, res);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL zero_sum got %08h required 00000000", res); end
    checks++; if (trace_q[trace_q.size()-2] !== NORM) begin errors++; $display("FAIL zero_sum_path got %0d required %0d", trace_q[trace_q.size()-2], NORM); end
    consume();
    run_op(32'h7F00_0000, 32'h7F00_0000, res);
    checks++; if (res !== 32'h7F80_0000) begin errors++; $display("FAIL overflow got %08h required 7f800000", res); end
    consume();
  endtask

  task automatic test_hold();
    logic [31:0] res;
    run_op(32'h4B80_0000, 32'h3F80_0000, res);
    checks++; if (res !== 32'h4B80_0000) begin errors++; $display("FAIL d24_result got %08h required 4b800000", res); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %0b required 1", i, out_valid); end
      checks++; if (result !== 32'h4B80_0000) begin errors++; $display("FAIL hold_result[%0d] got %08h required 4b800000", i, result); end
    end
    consume();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL after_consume valid=%0b ready=%0b required 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_in_align();
    logic [31:0] res;
    int n;
    @(negedge clk);
    A = 32'h4B80_0000;
    B = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (state_o != ALIGN && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (state_o !== ALIGN) begin errors++; $display("FAIL reach_align got %0d required %0d", state_o, ALIGN); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (state_o !== IDLE) begin errors++; $display("FAIL rst_align_state got %0d required %0d", state_o, IDLE); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_align_valid got %0b required 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_align_result got %08h required 00000000", result); end
    reset = 1'b0;
    run_op(32'h4040_0000, 32'hBF80_0000, res);
    checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL post_reset_add got %08h required 40000000", res); end
    consume();
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, expv;
    int ea, eb, kind;
    for (int k = 0; k < 400; k++) begin
      ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) * 252 + int'($urandom_range(1, 2))
                                       : int'($urandom_range(1, 254));
      a = {1'($urandom_range(0, 1)), ea[7:0], 23'($urandom)};
      kind = int'($urandom_range(0, 15));
      case (kind)
        0: b = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
        1: b = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom)};
        2: begin a[30:23] = 8'hFF; b = $urandom; end
        3: b = a ^ 32'h8000_0000;
        4: b = {~a[31], a[30:0] ^ 31'($urandom_range(0, 255))};
        default: begin
          eb = ea + int'($urandom_range(0, 60)) - 30;
          if (eb < 1) eb = 1;
          if (eb > 254) eb = 254;
          b = {1'($urandom_range(0, 1)), eb[7:0], 23'($urandom)};
        end
      endcase
      exp_q.push_back(ref_add(a, b));
      run_op(a, b, res);
      expv = exp_q.pop_front();
      checks++;
      if (res !== expv) begin
        errors++;
        $display("FAIL random[%0d] a=%08h b=%08h got %08h required %08h", k, a, b, res, expv);
      end
      consume();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_one_plus_one();
    test_align_one();
    test_cancel_and_overflow();
    test_hold();
    test_reset_in_align();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
